// File: rtl/student_reg_arbiter_pkg.sv
// Shared definitions for the two-requester register-bank arbiter.
// Optional feature macro: STUDENT_REG_ARBITER_LOCK_EN (see top module).
package student_reg_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREG  = 8;
    localparam int DEF_AW    = 3;

    // One-hot pulse vector for a requester index.
    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/student_reg_bank.sv
// Bank of NREG load-gated registers: write-address decode plus read mux.
// Addresses at or above NREG never load and read back as zero.
module student_reg_bank
    import student_reg_arbiter_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] regs [NREG];

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        logic             load;
        logic [WIDTH-1:0] q;

        assign load    = we && (addr == AW'(i));
        assign regs[i] = q;

        // Hold unless this register is addressed by a write.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                q <= '0;
            else if (load)
                q <= wdata;
        end
    end

    // Read mux; out-of-range index returns zero.
    always_comb begin
        rdata = '0;
        if (int'(addr) < NREG)
            rdata = regs[addr];
    end

endmodule

// File: rtl/student_reg_arbiter.sv
// Round-robin arbiter sharing one register bank between two requesters.
// Each access runs IDLE -> ACCESS (-> RESP for reads) -> IDLE.
// Optional macro STUDENT_REG_ARBITER_LOCK_EN adds a lock input that lets
// the last granted requester keep exclusive ownership across accesses.
module student_reg_arbiter
    import student_reg_arbiter_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req,
    input  logic [1:0]         we,
    input  logic [2*AW-1:0]    addr,
    input  logic [2*WIDTH-1:0] wdata,
`ifdef STUDENT_REG_ARBITER_LOCK_EN
    input  logic [1:0]         lock,
`endif
    output logic [1:0]         gnt,
    output logic [1:0]         rvalid,
    output logic [WIDTH-1:0]   rdata,
    output logic               busy
);

    state_t           state, state_nxt;
    logic             sel, sel_nxt, take;
    logic             last;
    logic             lwe;
    logic [AW-1:0]    laddr;
    logic [WIDTH-1:0] lwdata;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] bank_rdata;
    logic             bank_we;
    logic [1:0]       eff_req;

`ifdef STUDENT_REG_ARBITER_LOCK_EN
    logic lock_held;

    // While locked only the owner (the last selected requester) is heard.
    assign eff_req = lock_held ? (req & req_onehot(sel)) : req;

    // Lock state is re-evaluated on every ACCESS of the owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lock_held <= 1'b0;
        else if (state == ACCESS)
            lock_held <= lock[sel];
    end
`else
    assign eff_req = req;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state, arbitration and pulse outputs.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        take      = 1'b0;
        gnt       = 2'b00;
        rvalid    = 2'b00;
        bank_we   = 1'b0;
        case (state)
            IDLE: begin
                if (eff_req != 2'b00) begin
                    take      = 1'b1;
                    state_nxt = ACCESS;
                    // On a tie the requester that did not go last wins.
                    sel_nxt   = (eff_req == 2'b11) ? ~last : eff_req[REQ1];
                end
            end
            ACCESS: begin
                gnt       = req_onehot(sel);
                bank_we   = lwe;
                state_nxt = lwe ? IDLE : RESP;
            end
            RESP: begin
                rvalid    = req_onehot(sel);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, round-robin pointer and read-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel     <= 1'(REQ0);
            lwe     <= 1'b0;
            laddr   <= '0;
            lwdata  <= '0;
            last    <= 1'(REQ1);
            rdata_q <= '0;
        end else begin
            if (take) begin
                sel    <= sel_nxt;
                lwe    <= we[sel_nxt];
                laddr  <= sel_nxt ? addr[AW +: AW] : addr[0 +: AW];
                lwdata <= sel_nxt ? wdata[WIDTH +: WIDTH] : wdata[0 +: WIDTH];
            end
            if (state == ACCESS) begin
                last <= sel;
                if (!lwe)
                    rdata_q <= bank_rdata;
            end
        end
    end

    student_reg_bank #(
        .NREG  (NREG),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bank_we),
        .addr  (laddr),
        .wdata (lwdata),
        .rdata (bank_rdata)
    );

    assign rdata = rdata_q;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_student_reg_arbiter.sv
// Scoreboard bench for student_reg_arbiter: the driver predicts each access
// with a transaction-level model and queues the expected grant/read result;
// a negedge monitor pops and compares whatever the DUT presents.
module tb_student_reg_arbiter;

    localparam int NREG  = 8;
    localparam int WIDTH = 16;
    localparam int AW    = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         req = '0;
    logic [1:0]         we = '0;
    logic [2*AW-1:0]    addr = '0;
    logic [2*WIDTH-1:0] wdata = '0;
`ifdef STUDENT_REG_ARBITER_LOCK_EN
    logic [1:0]         lock = '0;
`endif
    logic [1:0]         gnt, rvalid;
    logic [WIDTH-1:0]   rdata;
    logic               busy;

    always #5 clk = ~clk;

    student_reg_arbiter #(.NREG(NREG), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
`ifdef STUDENT_REG_ARBITER_LOCK_EN
        .lock   (lock),
`endif
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .busy   (busy)
    );

    typedef struct {
        int               who;
        bit               rd;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t             gq[$];
    exp_t             rv_exp, mon_e;
    bit               rv_pend = 0;
    bit               mon_en = 0;
    logic [WIDTH-1:0] rd_model = '0;

    // Reference model state
    logic [WIDTH-1:0] mem [NREG];
    int               m_last = 1;
    bit               m_lock_held = 0;
    int               m_lock_owner = 0;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) mem[i] = '0;
        m_last = 1;
        m_lock_held = 0;
        m_lock_owner = 0;
        rd_model = '0;
        rv_pend = 0;
        gq.delete();
    endfunction

    // Decide who wins, what a read returns, and apply a write to the model.
    function automatic void predict(input logic [1:0] pat, input logic [1:0] w,
                                    input logic [2*AW-1:0] a, input logic [2*WIDTH-1:0] d,
                                    input logic [1:0] lk);
        logic [1:0] eff;
        int         win, ad;
        exp_t       e;
        eff = pat;
        if (m_lock_held) eff = pat & ((m_lock_owner == 1) ? 2'b10 : 2'b01);
        if (eff == 2'b11) win = 1 - m_last;
        else              win = eff[1] ? 1 : 0;
        ad = int'((a >> (win * AW)) & 6'(NREG - 1));
        e.who  = win;
        e.rd   = !w[win];
        e.data = e.rd ? mem[ad] : '0;
        if (w[win]) mem[ad] = d[win*WIDTH +: WIDTH];
        gq.push_back(e);
        m_last = win;
        m_lock_held = lk[win];
        m_lock_owner = win;
    endfunction

    // Monitor: grant checked against queue, rvalid expected exactly one cycle later.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rv_pend) begin
                chk("rvalid", rvalid, (rv_exp.who == 1) ? 2'b10 : 2'b01);
                chk("rdata", rdata, rv_exp.data);
                rd_model = rv_exp.data;
                rv_pend = 0;
            end else begin
                chk("rvalid_quiet", rvalid, 2'b00);
                chk("rdata_hold", rdata, rd_model);
            end
            if (gnt != 2'b00) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", gnt, 2'b00);
                end else begin
                    mon_e = gq.pop_front();
                    chk("gnt", gnt, (mon_e.who == 1) ? 2'b10 : 2'b01);
                    if (mon_e.rd) begin
                        rv_pend = 1;
                        rv_exp = mon_e;
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 20);
        chk("idle_wait", busy, 1'b0);
    endtask

    // One access round; starts at a negedge with the DUT idle.
    task automatic issue(input logic [1:0] pat, input logic [1:0] w,
                         input logic [2*AW-1:0] a, input logic [2*WIDTH-1:0] d,
                         input logic [1:0] lk);
        int lat;
        predict(pat, w, a, d, lk);
        req = pat; we = w; addr = a; wdata = d;
`ifdef STUDENT_REG_ARBITER_LOCK_EN
        lock = lk;
`endif
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (gnt == 2'b00 && lat < 10);
        chk("gnt_latency", lat, 1);
        req = 2'b00;
        wait_idle();
    endtask

    initial begin
        logic [2*AW-1:0] a;
        int ng, n;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_rvalid", rvalid, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdata", rdata, 16'h0);
        #1 rst_n = 1'b1;
        mon_en = 1;
        wait_idle();

        // Both held high for 4 read grants: expect 01,10,01,10
        a = 6'(($urandom_range(0, 7) << 3) | $urandom_range(0, 7));
        for (int k = 0; k < 4; k++) predict(2'b11, 2'b00, a, '0, 2'b00);
        req = 2'b11; we = 2'b00; addr = a;
        ng = 0; n = 0;
        while (ng < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (gnt != 2'b00) ng++;
        end
        chk("held_grants", ng, 4);
        req = 2'b00;
        wait_idle();

        // Write BEEF to 3 from requester 0, read it back via requester 1
        issue(2'b01, 2'b01, {3'd0, 3'd3}, {16'h0, 16'hBEEF}, 2'b00);
        issue(2'b10, 2'b00, {3'd3, 3'd0}, '0, 2'b00);

        // Write then immediate read of 5, neighbours untouched
        issue(2'b01, 2'b01, {3'd0, 3'd5}, {16'h0, 16'h1234}, 2'b00);
        issue(2'b01, 2'b00, {3'd0, 3'd5}, '0, 2'b00);
        issue(2'b10, 2'b00, {3'd4, 3'd0}, '0, 2'b00);
        issue(2'b01, 2'b00, {3'd0, 3'd6}, '0, 2'b00);
        issue(2'b10, 2'b00, {3'd5, 3'd0}, '0, 2'b00);

        // Idle: nothing moves, rdata holds (monitor checks rdata)
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_busy", busy, 1'b0);
            chk("idle_gnt", gnt, 2'b00);
            chk("idle_rvalid", rvalid, 2'b00);
        end

        // Reset during the ACCESS of a write of FFFF to 2
        #1 mon_en = 0;
        req = 2'b01; we = 2'b01; addr = {3'd0, 3'd2}; wdata = {16'h0, 16'hFFFF};
        @(negedge clk);
        chk("rst_mid_gnt_before", gnt, 2'b01);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_gnt", gnt, 2'b00);
        chk("rst_mid_rvalid", rvalid, 2'b00);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_rdata", rdata, 16'h0);
        req = 2'b00;
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1;
        wait_idle();
        issue(2'b01, 2'b00, {3'd0, 3'd2}, '0, 2'b00);
        // Tie right after reset-cleared pointer history goes by round robin
        issue(2'b11, 2'b01, {3'd1, 3'd1}, {16'hAAAA, 16'h5555}, 2'b00);
        issue(2'b11, 2'b00, {3'd1, 3'd1}, '0, 2'b00);

`ifdef STUDENT_REG_ARBITER_LOCK_EN
        // Requester 1 locks for 3 accesses while requester 0 also asks
        issue(2'b10, 2'b01, {3'd7, 3'd0}, {16'h7777, 16'h0}, 2'b10);
        issue(2'b11, 2'b00, {3'd7, 3'd0}, '0, 2'b10);
        issue(2'b11, 2'b01, {3'd6, 3'd0}, {16'h6666, 16'h0}, 2'b00);
        issue(2'b11, 2'b00, {3'd6, 3'd6}, '0, 2'b00);
`endif

        // Random traffic
        for (int k = 0; k < 80; k++) begin
            issue(2'($urandom_range(1, 3)), 2'($urandom), 6'($urandom),
                  {16'($urandom), 16'($urandom)}, 2'b00);
        end

        repeat (3) @(negedge clk);
        chk("queue_drain", gq.size(), 0);
        chk("rvalid_drain", rv_pend, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
